// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, stall hold and flush-to-bubble.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble cycle counters.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nxt;
  logic main_valid, skid_valid, accept, drain;
  logic load_main_in, load_main_skid, load_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  assign main_valid = state != EMPTY;
  assign skid_valid = state == TWO;
  assign in_ready   = ~skid_valid & ~stall_i & ~flush_i & rst_n;
  assign out_valid  = main_valid & ~stall_i;
  assign out_ctrl   = main_valid ? main_ctrl : CTRL_RST;
  assign out_data   = main_data;
  assign occ_o      = {1'b0, main_valid} + {1'b0, skid_valid};
  // accept already excludes stall/flush through in_ready; drain excludes stall through out_valid
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  always_comb begin
    load_main_in   = accept & (~main_valid | drain);
    load_skid      = accept & main_valid & ~drain;
    load_main_skid = drain & skid_valid & ~flush_i;
    state_nxt = flush_i    ? EMPTY :
                skid_valid ? (drain ? ONE : TWO) :
                main_valid ? (load_skid ? TWO : (accept | ~drain) ? ONE : EMPTY) :
                             (accept ? ONE : EMPTY);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      main_ctrl <= CTRL_RST;
      skid_ctrl <= CTRL_RST;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_ctrl <= CTRL_RST;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (!out_valid && !stall_i && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table, hand sequences and a queue-model random run for pipe_stage_skid.
module tb_pipe_stage_skid;
  localparam bit Z = 1'b0, H = 1'b1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall_i = 1'b0, flush_i = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_ctrl = '0;
  logic [95:0] in_data = '0;
  logic in_ready, out_valid;
  logic [7:0] out_ctrl;
  logic [95:0] out_data;
  logic [1:0] occ_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ_o(occ_o)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic iv, input logic ordy,
                       input logic [7:0] c, input logic [95:0] d);
    stall_i = st; flush_i = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(Z, Z, Z, Z, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic st, fl, iv, ordy;
    logic [7:0] c;
    logic [95:0] d;
    logic ov;
    logic [7:0] oc;
    logic [95:0] od;
    logic [1:0] occ;
    logic ir;
  } vec_t;
  vec_t tv[14];

  typedef struct {
    logic [7:0] c;
    logic [95:0] d;
  } ent_t;
  ent_t q[$];
  logic [95:0] hold_data;
  int stall_m, bubble_m;

  initial begin
    // outputs listed are those expected during the cycle the inputs are applied
    tv[0]  = '{Z, Z, H, Z, 8'h11, 96'hA5, Z, 8'h00, 96'h0,  2'd0, H};
    tv[1]  = '{Z, Z, H, Z, 8'h3C, 96'h5A, H, 8'h11, 96'hA5, 2'd1, H};
    tv[2]  = '{Z, Z, H, Z, 8'h33, 96'h77, H, 8'h11, 96'hA5, 2'd2, Z};
    tv[3]  = '{Z, Z, Z, H, 8'h00, 96'h0,  H, 8'h11, 96'hA5, 2'd2, Z};
    tv[4]  = '{Z, Z, Z, Z, 8'h00, 96'h0,  H, 8'h3C, 96'h5A, 2'd1, H};
    tv[5]  = '{H, Z, H, H, 8'h44, 96'h99, Z, 8'h3C, 96'h5A, 2'd1, Z};
    tv[6]  = '{H, Z, H, H, 8'h44, 96'h99, Z, 8'h3C, 96'h5A, 2'd1, Z};
    tv[7]  = '{H, Z, H, H, 8'h44, 96'h99, Z, 8'h3C, 96'h5A, 2'd1, Z};
    tv[8]  = '{Z, Z, Z, H, 8'h00, 96'h0,  H, 8'h3C, 96'h5A, 2'd1, H};
    tv[9]  = '{Z, Z, Z, H, 8'h00, 96'h0,  Z, 8'h00, 96'h5A, 2'd0, H};
    tv[10] = '{Z, Z, H, Z, 8'h55, 96'h10, Z, 8'h00, 96'h5A, 2'd0, H};
    tv[11] = '{Z, Z, H, Z, 8'h66, 96'h20, H, 8'h55, 96'h10, 2'd1, H};
    tv[12] = '{H, H, H, H, 8'h77, 96'h30, Z, 8'h55, 96'h10, 2'd2, Z};
    tv[13] = '{Z, Z, Z, Z, 8'h00, 96'h0,  Z, 8'h00, 96'h10, 2'd0, H};

    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_occ", {126'd0, occ_o}, 128'd0);
    do_reset();

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].fl, tv[i].iv, tv[i].ordy, tv[i].c, tv[i].d);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {127'd0, out_valid}, {127'd0, tv[i].ov});
      chk($sformatf("vec%0d_out_ctrl", i), {120'd0, out_ctrl}, {120'd0, tv[i].oc});
      chk($sformatf("vec%0d_out_data", i), {32'd0, out_data}, {32'd0, tv[i].od});
      chk($sformatf("vec%0d_occ", i), {126'd0, occ_o}, {126'd0, tv[i].occ});
      chk($sformatf("vec%0d_in_ready", i), {127'd0, in_ready}, {127'd0, tv[i].ir});
      @(negedge clk);
    end

    // asynchronous reset while both entries are held
    drive(Z, Z, H, Z, 8'hE1, 96'hDEAD);
    @(negedge clk);
    drive(Z, Z, H, Z, 8'hE2, 96'hBEEF);
    @(negedge clk);
    drive(Z, Z, Z, Z, '0, '0);
    #1;
    chk("pre_rst_occ", {126'd0, occ_o}, 128'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("async_rst_occ", {126'd0, occ_o}, 128'd0);
    chk("async_rst_out_ctrl", {120'd0, out_ctrl}, 128'd0);
    chk("async_rst_out_data", {32'd0, out_data}, 128'd0);
    chk("async_rst_in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) begin
      drive(Z, Z, H, H, 8'(i), 96'(i));
      #1;
      if (i > 1) begin
        chk($sformatf("stream%0d_data", i - 1), {32'd0, out_data}, 128'(i - 1));
        chk($sformatf("stream%0d_valid", i - 1), {127'd0, out_valid}, 128'd1);
        chk($sformatf("stream%0d_occ", i - 1), {126'd0, occ_o}, 128'd1);
      end
      @(negedge clk);
    end
    drive(Z, Z, Z, H, '0, '0);
    #1;
    chk("stream8_data", {32'd0, out_data}, 128'd8);
    chk("stream8_valid", {127'd0, out_valid}, 128'd1);
    @(negedge clk);
    #1;
    chk("stream_drained_occ", {126'd0, occ_o}, 128'd0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    repeat (5) begin
      drive(H, Z, Z, Z, '0, '0);
      @(negedge clk);
    end
    repeat (3) begin
      drive(Z, Z, Z, Z, '0, '0);
      @(negedge clk);
    end
    #1;
    chk("perf_stall_cnt", {96'd0, stall_cnt}, 128'd5);
    chk("perf_bubble_cnt", {96'd0, bubble_cnt}, 128'd3);
`endif

    // randomized run against a queue model
    do_reset();
    q.delete();
    hold_data = '0;
    stall_m = 0;
    bubble_m = 0;
    for (int n = 0; n < 600; n++) begin
      automatic bit st = ($urandom_range(7) == 0);
      automatic bit fl = ($urandom_range(15) == 0);
      automatic bit iv = ($urandom_range(3) != 0);
      automatic bit ordy = ($urandom_range(2) != 0);
      automatic ent_t e;
      automatic bit acc, drn;
      e.c = 8'($urandom);
      e.d = {$urandom, $urandom, $urandom};
      drive(st, fl, iv, ordy, e.c, e.d);
      #1;
      chk("rnd_out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0 && !st});
      chk("rnd_out_ctrl", {120'd0, out_ctrl}, {120'd0, q.size() > 0 ? q[0].c : 8'h00});
      chk("rnd_out_data", {32'd0, out_data}, {32'd0, hold_data});
      chk("rnd_occ", {126'd0, occ_o}, 128'(q.size()));
      chk("rnd_in_ready", {127'd0, in_ready}, {127'd0, q.size() < 2 && !st && !fl});
      if (st) stall_m++;
      if (q.size() == 0 && !st) bubble_m++;
      acc = iv && q.size() < 2 && !st && !fl;
      drn = q.size() > 0 && !st && ordy;
      if (fl) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (q.size() > 0) hold_data = q[0].d;
      @(negedge clk);
    end
`ifdef PIPE_STAGE_PERF_EN
    #1;
    chk("rnd_stall_cnt", {96'd0, stall_cnt}, 128'(stall_m));
    chk("rnd_bubble_cnt", {96'd0, bubble_cnt}, 128'(bubble_m));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (e.g. E->M).
- Generic payload (data + control) with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, stall hold, and flush-to-bubble.
- Instanced between any two core stages (D/E, E/M, M/W); control fields are cleared on flush, data fields are not.

Parameters:
- DATA_W, 96, width of datapath payload (ALU result, write data, PC+4…); never cleared by flush.
- CTRL_W, 8, width of control payload (RegWrite, ResultSrc, MemWrite, Rd…); zeroed on flush/reset.
- CTRL_RST, 0, reset/bubble value of the control payload (CTRL_W bits).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  freeze stage (hazard unit Stall_x)
- flush_i  in  1  drop all held entries (hazard unit Flush_x)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control payload
- in_data  in  DATA_W  upstream data payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control (CTRL_RST when out_valid=0)
- out_data  out  DATA_W  head data
- occ_o  out  2  entries held (0..2)

Behaviour:
- Storage: main reg (head) + skid reg; each has valid, ctrl, data. States: EMPTY (occ 0), ONE (main only), TWO (main+skid).
- Reset (async, rst_n=0): both valids 0, ctrl regs = CTRL_RST, data regs = 0; out_valid=0, out_ctrl=CTRL_RST, out_data=0, in_ready=0 during reset, occ_o=0. Release takes effect on the next rising edge; no partial state retained on mid-operation reset.
- in_ready = ~skid_valid & ~stall_i & ~flush_i & rst_n (combinational).
- out_valid = main_valid & ~stall_i. out_ctrl = main_valid ? main_ctrl : CTRL_RST. out_data = main_data (held).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Priority per edge: flush > stall > normal.
- flush_i=1: both valids -> 0, both ctrl -> CTRL_RST, data unchanged; in_valid that cycle is dropped; next state EMPTY.
- stall_i=1 (no flush): all registers hold; no accept, no drain.
- Normal transitions:
  - EMPTY: accept -> ONE (main <= in).
  - ONE: accept&drain -> ONE (main <= in); accept only -> TWO (skid <= in); drain only -> EMPTY.
  - TWO: in_ready=0; drain -> ONE (main <= skid, skid cleared to CTRL_RST ctrl).
- Latency: 1 cycle in->out when downstream ready; sustained throughput 1/cycle; ordering strictly FIFO.
- No payload combinationally reaches outputs from inputs (full register stage); out_ready affects only state, not same-cycle outputs.
- occ_o = main_valid + skid_valid.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: extra outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0]; stall_cnt increments each cycle stall_i=1; bubble_cnt increments each cycle out_valid=0 & ~stall_i; both saturate at 32'hFFFF_FFFF, reset to 0 by rst_n, and are not cleared by flush_i.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-traffic with occ=2 -> out_valid=0, occ_o=0, out_ctrl=CTRL_RST, out_data=0 immediately (async).
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on cycles 1..8, out_valid=1 each, occ_o=1 throughout.
- Backpressure: out_ready=0 after entry A=0xA5 is in main; send B=0x5A -> occ_o=2, in_ready=0; raise out_ready -> A then B delivered in order, no loss, and in_ready=1 again once skid is empty.
- Stall: occ=1 holding ctrl=0x3C; stall_i=1 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, occ_o=1; release -> ctrl 0x3C presented, the stalled inputs are not captured.
- Flush: occ=2, flush_i=1 with in_valid=1 and stall_i=1 -> next cycle occ_o=0, out_ctrl=CTRL_RST, out_data unchanged, flushed input absent.
- PIPE_STAGE_PERF_EN: 5 stall cycles + 3 empty cycles -> stall_cnt_o=5, bubble_cnt_o=3; a counter preloaded to 0xFFFF_FFFF stays at 0xFFFF_FFFF.
